// File: rtl/alu_reg_bank.sv
// alu_reg_bank: per-channel operand/command registers, round-robin issue to one shared ALU port.
// Read latency 1 cycle; grant held until alu_ready. Optional irq/CTRL.IE via ALU_REG_BANK_IRQ_EN.
module alu_reg_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int OP_WIDTH   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      rd_wr,
    input  logic [$clog2(NUM_CH)+2:0] addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [OP_WIDTH-1:0]       alu_op,
    output logic [$clog2(NUM_CH)-1:0] alu_ch,
    input  logic                      alu_res_valid,
    input  logic [$clog2(NUM_CH)-1:0] alu_res_ch,
    input  logic [DATA_WIDTH-1:0]     alu_res,
    output logic [NUM_CH-1:0]         busy
`ifdef ALU_REG_BANK_IRQ_EN
    ,
    output logic                      irq
`endif
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_ISS = 2'd2} state_t;

    state_t                r_state     [NUM_CH];
    state_t                w_state_nxt [NUM_CH];
    logic [DATA_WIDTH-1:0] r_a   [NUM_CH];
    logic [DATA_WIDTH-1:0] r_b   [NUM_CH];
    logic [DATA_WIDTH-1:0] r_res [NUM_CH];
    logic [OP_WIDTH-1:0]   r_op  [NUM_CH];
    logic [NUM_CH-1:0]     r_done, r_ovr, w_done_nxt, w_ovr_nxt;
    logic                  r_gnt_vld;
    logic [CH_W-1:0]       r_gnt_ch, r_last, w_pick_ch, w_c;
    logic                  w_pick_vld, w_accept, w_wr, w_rd;
    logic [DATA_WIDTH-1:0] r_alu_a, r_alu_b, r_rd_data, w_rd_mux;
    logic [OP_WIDTH-1:0]   r_alu_op;
    logic [CH_W-1:0]       w_ch;
    logic [2:0]            w_idx;
`ifdef ALU_REG_BANK_IRQ_EN
    logic [NUM_CH-1:0]     r_ie;
    logic                  r_irq;
    assign irq = r_irq;
`endif

    assign w_wr      = enable & ~rd_wr;
    assign w_rd      = enable & rd_wr;
    assign w_ch      = addr[CH_W+2:3];
    assign w_idx     = addr[2:0];
    assign w_accept  = r_gnt_vld & alu_ready;
    assign rd_data   = r_rd_data;
    assign alu_valid = r_gnt_vld;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign alu_ch    = r_gnt_ch;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_busy
        assign busy[g] = (r_state[g] != S_IDLE);
    end

    // Set events take priority over the read-to-clear of STATUS in the same cycle.
    always_comb begin
        w_done_nxt = r_done;
        w_ovr_nxt  = r_ovr;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_rd && w_ch == CH_W'(i) && w_idx == 3'd5) begin
                w_done_nxt[i] = 1'b0;
                w_ovr_nxt[i]  = 1'b0;
            end
            if (w_wr && w_ch == CH_W'(i) && w_idx <= 3'd3 && r_state[i] != S_IDLE)
                w_ovr_nxt[i] = 1'b1;
            case (r_state[i])
                S_IDLE: if (w_wr && w_ch == CH_W'(i) && w_idx == 3'd3 && wr_data[0]) begin
                    w_state_nxt[i] = S_PEND;
                    w_done_nxt[i]  = 1'b0;
                end
                S_PEND: if (w_accept && r_gnt_ch == CH_W'(i)) w_state_nxt[i] = S_ISS;
                S_ISS: if (alu_res_valid && alu_res_ch == CH_W'(i)) begin
                    w_state_nxt[i] = S_IDLE;
                    w_done_nxt[i]  = 1'b1;
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    // Descending scan so the nearest pending channel after r_last wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_ch  = '0;
        w_c        = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_c = r_last + CH_W'(k);
            if (r_state[w_c] == S_PEND) begin
                w_pick_vld = 1'b1;
                w_pick_ch  = w_c;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            3'd0: w_rd_mux = r_a[w_ch];
            3'd1: w_rd_mux = r_b[w_ch];
            3'd2: w_rd_mux[OP_WIDTH-1:0] = r_op[w_ch];
`ifdef ALU_REG_BANK_IRQ_EN
            3'd3: w_rd_mux[1] = r_ie[w_ch];
`endif
            3'd4: w_rd_mux = r_res[w_ch];
            3'd5: w_rd_mux[2:0] = {r_ovr[w_ch], r_done[w_ch], busy[w_ch]};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) r_state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_a[i]   <= '1;
                r_b[i]   <= '1;
                r_op[i]  <= '1;
                r_res[i] <= '0;
            end
            r_done <= '0;
            r_ovr  <= '0;
`ifdef ALU_REG_BANK_IRQ_EN
            r_ie   <= '0;
`endif
        end else begin
            r_done <= w_done_nxt;
            r_ovr  <= w_ovr_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr && w_ch == CH_W'(i) && r_state[i] == S_IDLE) begin
                    case (w_idx)
                        3'd0: r_a[i]  <= wr_data;
                        3'd1: r_b[i]  <= wr_data;
                        3'd2: r_op[i] <= wr_data[OP_WIDTH-1:0];
`ifdef ALU_REG_BANK_IRQ_EN
                        3'd3: r_ie[i] <= wr_data[1];
`endif
                        default: ;
                    endcase
                end
                if (alu_res_valid && alu_res_ch == CH_W'(i) && r_state[i] == S_ISS)
                    r_res[i] <= alu_res;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt_vld <= 1'b0;
            r_gnt_ch  <= '0;
            r_last    <= CH_W'(NUM_CH - 1);
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
        end else if (w_accept) begin
            r_gnt_vld <= 1'b0;
        end else if (!r_gnt_vld && w_pick_vld) begin
            r_gnt_vld <= 1'b1;
            r_gnt_ch  <= w_pick_ch;
            r_last    <= w_pick_ch;
            r_alu_a   <= r_a[w_pick_ch];
            r_alu_b   <= r_b[w_pick_ch];
            r_alu_op  <= r_op[w_pick_ch];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '1;
`ifdef ALU_REG_BANK_IRQ_EN
            r_irq     <= 1'b0;
`endif
        end else begin
            if (w_rd) r_rd_data <= w_rd_mux;
`ifdef ALU_REG_BANK_IRQ_EN
            r_irq <= |(r_done & r_ie);
`endif
        end
    end
endmodule

// File: tb/tb_alu_reg_bank.sv
// Directed, table-driven bench for alu_reg_bank (NUM_CH=4, DATA_WIDTH=8, OP_WIDTH=3).
module tb_alu_reg_bank;
    logic       clk, reset, enable, rd_wr, alu_ready, alu_res_valid;
    logic [4:0] addr;
    logic [7:0] wr_data, rd_data, alu_a, alu_b, alu_res;
    logic       alu_valid;
    logic [2:0] alu_op;
    logic [1:0] alu_ch, alu_res_ch;
    logic [3:0] busy;
`ifdef ALU_REG_BANK_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int failures = 0;

    alu_reg_bank #(.DATA_WIDTH(8), .NUM_CH(4), .OP_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rd_wr(rd_wr), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ch(alu_ch),
        .alu_res_valid(alu_res_valid), .alu_res_ch(alu_res_ch), .alu_res(alu_res),
        .busy(busy)
`ifdef ALU_REG_BANK_IRQ_EN
        , .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rd;
        logic [1:0] ch;
        logic [2:0] idx;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic bus_write(input logic [1:0] ch, input logic [2:0] idx, input logic [7:0] d);
        enable = 1'b1; rd_wr = 1'b0; addr = {ch, idx}; wr_data = d;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] ch, input logic [2:0] idx, input logic [7:0] exp,
                            input string name);
        enable = 1'b1; rd_wr = 1'b1; addr = {ch, idx};
        @(negedge clk);
        enable = 1'b0;
        check(name, rd_data, exp);
    endtask

    task automatic send_res(input logic [1:0] ch, input logic [7:0] v);
        alu_res_valid = 1'b1; alu_res_ch = ch; alu_res = v;
        @(negedge clk);
        alu_res_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (alu_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s: alu_valid got 0 expected 1 within 20 cycles", name);
        end
    endtask

    vec_t tbl[14];
    logic [1:0] order[3];
    logic [7:0] ch2_a, ch2_b;
    logic [2:0] ch2_op;
    int   n_ord;
    logic seen;

    initial begin
        tbl[0]  = '{1'b0, 2'd2, 3'd0, 8'hA5, 8'h00};
        tbl[1]  = '{1'b1, 2'd2, 3'd0, 8'h00, 8'hA5};
        tbl[2]  = '{1'b0, 2'd2, 3'd1, 8'h3C, 8'h00};
        tbl[3]  = '{1'b1, 2'd2, 3'd1, 8'h00, 8'h3C};
        tbl[4]  = '{1'b0, 2'd2, 3'd2, 8'hFE, 8'h00};
        tbl[5]  = '{1'b1, 2'd2, 3'd2, 8'h00, 8'h06};
        tbl[6]  = '{1'b0, 2'd2, 3'd3, 8'h04, 8'h00};
        tbl[7]  = '{1'b1, 2'd2, 3'd3, 8'h00, 8'h00};
        tbl[8]  = '{1'b1, 2'd2, 3'd5, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 2'd2, 3'd6, 8'h11, 8'h00};
        tbl[10] = '{1'b1, 2'd2, 3'd6, 8'h00, 8'h00};
        tbl[11] = '{1'b1, 2'd2, 3'd7, 8'h00, 8'h00};
        tbl[12] = '{1'b1, 2'd2, 3'd4, 8'h00, 8'h00};
        tbl[13] = '{1'b1, 2'd3, 3'd1, 8'h00, 8'hFF};

        reset = 1'b0; enable = 1'b0; rd_wr = 1'b0; addr = '0; wr_data = '0;
        alu_ready = 1'b0; alu_res_valid = 1'b0; alu_res_ch = '0; alu_res = '0;
        repeat (2) @(negedge clk);
        check("reset rd_data", rd_data, 8'hFF);
        check("reset alu_valid", alu_valid, 0);
        check("reset busy", busy, 0);
        check("reset alu_a", alu_a, 0);
        check("reset alu_ch/op", {alu_ch, alu_op}, 0);
        reset = 1'b1;
        @(negedge clk);

        bus_read(2'd0, 3'd0, 8'hFF, "reset ch0 A");
        bus_read(2'd0, 3'd2, 8'h07, "reset ch0 OP");
        bus_read(2'd0, 3'd5, 8'h00, "reset ch0 STATUS");
        check("idle alu_valid", alu_valid, 0);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rd)
                bus_read(tbl[i].ch, tbl[i].idx, tbl[i].exp, $sformatf("table[%0d]", i));
            else
                bus_write(tbl[i].ch, tbl[i].idx, tbl[i].dat);
        end
        check("table no launch busy", busy, 0);

        // Single issue on ch1
        alu_ready = 1'b1;
        bus_write(2'd1, 3'd0, 8'h12);
        bus_write(2'd1, 3'd1, 8'h34);
        bus_write(2'd1, 3'd2, 8'h03);
        bus_write(2'd1, 3'd3, 8'h01);
        check("ch1 busy after launch", busy, 4'b0010);
        wait_valid("ch1 issue");
        check("ch1 issue fields", {alu_ch, alu_a, alu_b, alu_op}, {2'd1, 8'h12, 8'h34, 3'd3});
        @(negedge clk);
        bus_read(2'd1, 3'd5, 8'h01, "ch1 STATUS issued");
        send_res(2'd1, 8'h46);
        check("ch1 busy after result", busy, 0);
        bus_read(2'd1, 3'd4, 8'h46, "ch1 RESULT");
        bus_read(2'd1, 3'd5, 8'h02, "ch1 STATUS done");
        bus_read(2'd1, 3'd5, 8'h00, "ch1 STATUS cleared");

        // Three launches under backpressure, then round-robin drain
        alu_ready = 1'b0;
        bus_write(2'd0, 3'd0, 8'h01);
        bus_write(2'd0, 3'd1, 8'h02);
        bus_write(2'd0, 3'd2, 8'h01);
        bus_write(2'd0, 3'd3, 8'h01);
        bus_write(2'd2, 3'd3, 8'h01);
        bus_write(2'd3, 3'd3, 8'h01);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("held grant cycle %0d", c), {alu_valid, alu_ch, alu_a, alu_b, alu_op},
                  {1'b1, 2'd0, 8'h01, 8'h02, 3'd1});
            @(negedge clk);
        end
        check("busy while pending", busy, 4'b1101);
        alu_ready = 1'b1;
        n_ord = 0;
        ch2_a = '0; ch2_b = '0; ch2_op = '0;
        for (int n = 0; n < 20 && n_ord < 3; n++) begin
            if (alu_valid) begin
                order[n_ord] = alu_ch;
                if (alu_ch == 2'd2) begin ch2_a = alu_a; ch2_b = alu_b; ch2_op = alu_op; end
                n_ord++;
            end
            @(negedge clk);
        end
        check("issue count", n_ord, 3);
        check("issue order", {order[0], order[1], order[2]}, {2'd0, 2'd2, 2'd3});
        check("ch2 issue fields", {ch2_a, ch2_b, ch2_op}, {8'hA5, 8'h3C, 3'd6});
        check("busy all issued", busy, 4'b1101);

        // Overrun on busy channel
        bus_write(2'd2, 3'd0, 8'h55);
        bus_read(2'd2, 3'd0, 8'hA5, "ch2 A unchanged");
        bus_read(2'd2, 3'd5, 8'h05, "ch2 STATUS overrun");
        bus_write(2'd2, 3'd1, 8'h77);
        send_res(2'd2, 8'hE1);
        bus_read(2'd2, 3'd5, 8'h06, "ch2 STATUS done+overrun");
        bus_read(2'd2, 3'd4, 8'hE1, "ch2 RESULT");
        bus_read(2'd2, 3'd5, 8'h00, "ch2 STATUS cleared");
        bus_read(2'd2, 3'd1, 8'h3C, "ch2 B unchanged");

        // STATUS read coincident with result on ch3
        enable = 1'b1; rd_wr = 1'b1; addr = {2'd3, 3'd5};
        alu_res_valid = 1'b1; alu_res_ch = 2'd3; alu_res = 8'h99;
        @(negedge clk);
        enable = 1'b0; alu_res_valid = 1'b0;
        check("ch3 STATUS coincident", rd_data, 8'h01);
        bus_read(2'd3, 3'd5, 8'h02, "ch3 done survives read");
        bus_read(2'd3, 3'd5, 8'h00, "ch3 STATUS cleared");

        // Launch and result on ch0 in the same cycle
        enable = 1'b1; rd_wr = 1'b0; addr = {2'd0, 3'd3}; wr_data = 8'h01;
        alu_res_valid = 1'b1; alu_res_ch = 2'd0; alu_res = 8'h3B;
        @(negedge clk);
        enable = 1'b0; alu_res_valid = 1'b0;
        check("launch dropped busy", busy, 0);
        seen = 1'b0;
        repeat (4) begin
            if (alu_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("no issue after dropped launch", seen, 0);
        bus_read(2'd0, 3'd5, 8'h06, "ch0 STATUS done+overrun");
        bus_read(2'd0, 3'd4, 8'h3B, "ch0 RESULT");

        // Result for idle channel is ignored
        send_res(2'd3, 8'h11);
        bus_read(2'd3, 3'd4, 8'h99, "ch3 RESULT after stray");
        bus_read(2'd3, 3'd5, 8'h00, "ch3 STATUS after stray");

        // Reset while ch0 issued
        bus_write(2'd0, 3'd3, 8'h01);
        wait_valid("ch0 reissue");
        @(negedge clk);
        check("ch0 issued busy", busy, 4'b0001);
        reset = 1'b0;
        @(negedge clk);
        check("mid reset busy", busy, 0);
        check("mid reset alu_valid", alu_valid, 0);
        check("mid reset rd_data", rd_data, 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        send_res(2'd0, 8'h5A);
        check("post reset busy", busy, 0);
        bus_read(2'd0, 3'd4, 8'h00, "post reset RESULT");
        bus_read(2'd0, 3'd5, 8'h00, "post reset STATUS");
        bus_read(2'd0, 3'd0, 8'hFF, "post reset A");

`ifdef ALU_REG_BANK_IRQ_EN
        bus_write(2'd1, 3'd3, 8'h03);
        bus_read(2'd1, 3'd3, 8'h02, "ch1 CTRL IE");
        wait_valid("ch1 irq issue");
        @(negedge clk);
        send_res(2'd1, 8'h21);
        check("irq not yet", irq, 0);
        @(negedge clk);
        check("irq asserted", irq, 1);
        bus_read(2'd1, 3'd5, 8'h02, "ch1 STATUS irq");
        check("irq before drop", irq, 1);
        @(negedge clk);
        check("irq dropped", irq, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
